// File: rtl/ucode_sequencer_pkg.sv
// Shared definitions for the micro-PC sequencer: next-address modes, microword
// field offsets and the default vector/dispatch addresses.
package ucode_sequencer_pkg;

  typedef enum logic [2:0] {
    NM_NEXT     = 3'd0,
    NM_JUMP     = 3'd1,
    NM_DISPATCH = 3'd2,
    NM_END      = 3'd3,
    NM_CBR      = 3'd4,
    NM_HALT     = 3'd5,
    NM_END6     = 3'd6,
    NM_END7     = 3'd7
  } nmode_t;

  typedef enum logic {
    PH_SETUP = 1'b0,
    PH_M     = 1'b1
  } phase_t;

  localparam int unsigned NMODE_LSB  = 0;
  localparam int unsigned WAIT_BIT   = 3;
  localparam int unsigned TARGET_LSB = 4;

  localparam int unsigned DEF_IW  = 16;
  localparam int unsigned DEF_OPW = 6;
  localparam int unsigned DEF_UA  = 8;
  localparam int unsigned DEF_UW  = 40;

  localparam logic [7:0]  DEF_FETCH_ADDR = 8'd2;
  localparam logic [7:0]  DEF_DISP_BASE  = 8'd64;
  localparam logic [7:0]  DEF_TRAP_VEC   = 8'd250;
  localparam logic [7:0]  DEF_IRQ_VEC    = 8'd252;
  localparam logic [15:0] DEF_HALT_INSTR = 16'hfe00;

endpackage

// File: rtl/ucode_sequencer_if.sv
// Sequencer-to-core signal bundle: IR/ROM/flag inputs and micro-PC/control outputs.
interface ucode_sequencer_if
  import ucode_sequencer_pkg::*;
#(
  parameter int unsigned IW = DEF_IW,
  parameter int unsigned UA = DEF_UA,
  parameter int unsigned UW = DEF_UW
) ();
  logic [IW-1:0]      instr;
  logic [UW-1:0]      uword;
  logic               cond_true;
  logic               mem_ready;
  logic               trap_r;
  logic               irq_r;
  logic [UA-1:0]      uaddr;
  logic [UW-UA-5:0]   ctrl;
  logic               phase_m;
  logic               stall;
  logic               irq_ack;
  logic               HLT;

  modport master (
    input  instr, uword, cond_true, mem_ready, trap_r, irq_r,
    output uaddr, ctrl, phase_m, stall, irq_ack, HLT
  );

  modport slave (
    output instr, uword, cond_true, mem_ready, trap_r, irq_r,
    input  uaddr, ctrl, phase_m, stall, irq_ack, HLT
  );
endinterface

// File: rtl/ucode_sequencer_next_addr.sv
// Combinational next-micro-address selection from the microword's nmode field.
module uc_next_addr
  import ucode_sequencer_pkg::*;
#(
  parameter int unsigned UA         = DEF_UA,
  parameter int unsigned OPW        = DEF_OPW,
  parameter logic [UA-1:0] FETCH_ADDR = UA'(DEF_FETCH_ADDR),
  parameter logic [UA-1:0] DISP_BASE  = UA'(DEF_DISP_BASE),
  parameter logic [UA-1:0] IRQ_VEC    = UA'(DEF_IRQ_VEC)
) (
  input  nmode_t         i_nmode,
  input  logic [UA-1:0]  i_uaddr,
  input  logic [UA-1:0]  i_target,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_cond_true,
  input  logic           i_irq_r,
  input  logic           i_halt_instr,
  output logic [UA-1:0]  o_next,
  output logic           o_take_irq,
  output logic           o_go_halt
);
  logic [UA-1:0] w_inc;

  assign w_inc = i_uaddr + UA'(1);

  always_comb begin
    o_next     = w_inc;
    o_take_irq = 1'b0;
    o_go_halt  = 1'b0;
    case (i_nmode)
      NM_NEXT:     o_next = w_inc;
      NM_JUMP:     o_next = i_target;
      NM_DISPATCH: begin
        o_next    = DISP_BASE + UA'(i_opcode);
        o_go_halt = i_halt_instr;
      end
      NM_CBR:      o_next = i_cond_true ? i_target : w_inc;
      NM_HALT:     o_go_halt = 1'b1;
      default: begin
        // END and the unused encodings 6/7 all close the instruction
        o_next     = i_irq_r ? IRQ_VEC : FETCH_ADDR;
        o_take_irq = i_irq_r;
      end
    endcase
  end
endmodule

// File: rtl/ucode_sequencer.sv
// Micro-PC sequencer: two-phase steps, memory wait, trap/irq vectoring and sticky halt.
module ucode_sequencer
  import ucode_sequencer_pkg::*;
#(
  parameter int unsigned IW  = DEF_IW,
  parameter int unsigned OPW = DEF_OPW,
  parameter int unsigned UA  = DEF_UA,
  parameter int unsigned UW  = DEF_UW,
  parameter logic [UA-1:0] FETCH_ADDR = UA'(DEF_FETCH_ADDR),
  parameter logic [UA-1:0] DISP_BASE  = UA'(DEF_DISP_BASE),
  parameter logic [UA-1:0] TRAP_VEC   = UA'(DEF_TRAP_VEC),
  parameter logic [UA-1:0] IRQ_VEC    = UA'(DEF_IRQ_VEC),
  parameter logic [IW-1:0] HALT_INSTR = IW'(DEF_HALT_INSTR)
) (
  input logic              clk,
  input logic              reset,
  ucode_sequencer_if.master bus
);
  phase_t         r_phase, w_phase_nxt;
  logic [UA-1:0]  r_uaddr, w_uaddr_nxt;
  logic           r_hlt, w_hlt_nxt;
  logic           r_irq_ack, w_irq_ack_nxt;

  logic [OPW-1:0] w_opcode;
  logic [UA-1:0]  w_next;
  logic           w_take_irq;
  logic           w_go_halt;
  logic           w_wait_blk;

  // Short-form opcodes (msb clear) use only the two bits below the msb
  assign w_opcode   = bus.instr[IW-1] ? bus.instr[IW-2 -: OPW]
                                      : OPW'(bus.instr[IW-2 -: 2]);
  assign w_wait_blk = bus.uword[WAIT_BIT] & ~bus.mem_ready;

  uc_next_addr #(
    .UA         (UA),
    .OPW        (OPW),
    .FETCH_ADDR (FETCH_ADDR),
    .DISP_BASE  (DISP_BASE),
    .IRQ_VEC    (IRQ_VEC)
  ) u_next (
    .i_nmode      (nmode_t'(bus.uword[NMODE_LSB +: 3])),
    .i_uaddr      (r_uaddr),
    .i_target     (bus.uword[TARGET_LSB +: UA]),
    .i_opcode     (w_opcode),
    .i_cond_true  (bus.cond_true),
    .i_irq_r      (bus.irq_r),
    .i_halt_instr (bus.instr == HALT_INSTR),
    .o_next       (w_next),
    .o_take_irq   (w_take_irq),
    .o_go_halt    (w_go_halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase   <= PH_SETUP;
      r_uaddr   <= FETCH_ADDR;
      r_hlt     <= 1'b0;
      r_irq_ack <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_uaddr   <= w_uaddr_nxt;
      r_hlt     <= w_hlt_nxt;
      r_irq_ack <= w_irq_ack_nxt;
    end
  end

  // Commit priority: trap > halt > stall > nmode (irq folded into END)
  always_comb begin
    w_phase_nxt   = r_phase;
    w_uaddr_nxt   = r_uaddr;
    w_hlt_nxt     = r_hlt;
    w_irq_ack_nxt = 1'b0;
    if (!r_hlt) begin
      case (r_phase)
        PH_SETUP: w_phase_nxt = PH_M;
        PH_M: begin
          if (bus.trap_r) begin
            w_uaddr_nxt = TRAP_VEC;
            w_phase_nxt = PH_SETUP;
          end else if (w_go_halt) begin
            w_hlt_nxt = 1'b1;
          end else if (!w_wait_blk) begin
            w_uaddr_nxt   = w_next;
            w_phase_nxt   = PH_SETUP;
            w_irq_ack_nxt = w_take_irq;
          end
        end
        default: w_phase_nxt = PH_SETUP;
      endcase
    end
  end

  assign bus.uaddr   = r_uaddr;
  assign bus.phase_m = (r_phase == PH_M);
  assign bus.stall   = (r_phase == PH_M) & w_wait_blk & ~r_hlt;
  assign bus.irq_ack = r_irq_ack;
  assign bus.HLT     = r_hlt;
  assign bus.ctrl    = r_hlt ? '0 : bus.uword[UW-1:UA+4];
endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed-vector bench for ucode_sequencer with a queue-based scoreboard.
module tb_ucode_sequencer;
  logic clk = 1'b0;
  logic reset;

  ucode_sequencer_if #(.IW(16), .UA(8), .UW(40)) bus ();

  ucode_sequencer #(
    .IW (16), .OPW (6), .UA (8), .UW (40),
    .FETCH_ADDR (8'd2), .DISP_BASE (8'd64), .TRAP_VEC (8'd250),
    .IRQ_VEC (8'd252), .HALT_INSTR (16'hfe00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [39:0] rom [256];
  assign bus.uword = rom[bus.uaddr];

  function automatic logic [27:0] ctrl_of(input logic [7:0] a);
    return 28'h5A50000 | {20'h0, a};
  endfunction

  function automatic logic [39:0] mw(input logic [2:0] nm, input logic w,
                                     input logic [7:0] tgt, input logic [7:0] a);
    return {ctrl_of(a), tgt, w, nm};
  endfunction

  typedef struct {
    string       name;
    logic [7:0]  ua;
    logic        ph;
    logic        st;
    logic        ack;
    logic        hlt;
    logic [27:0] ctrl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  event sample_ev;

  task automatic push(input string name, input logic [7:0] ua, input logic ph,
                      input logic st, input logic ack, input logic hlt);
    exp_t e;
    e.name = name; e.ua = ua; e.ph = ph; e.st = st; e.ack = ack; e.hlt = hlt;
    e.ctrl = hlt ? 28'h0 : ctrl_of(ua);
    q.push_back(e);
  endtask

  task automatic cyc(input string name, input logic [7:0] ua, input logic ph,
                     input logic st = 1'b0, input logic ack = 1'b0, input logic hlt = 1'b0);
    @(posedge clk);
    #1;
    push(name, ua, ph, st, ack, hlt);
    @(negedge clk);
    #1;
  endtask

  // Check without waiting for a clock edge (asynchronous reset effects)
  task automatic snap(input string name, input logic [7:0] ua, input logic ph,
                      input logic hlt = 1'b0);
    #1;
    push(name, ua, ph, 1'b0, 1'b0, hlt);
    -> sample_ev;
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (bus.uaddr !== e.ua || bus.phase_m !== e.ph || bus.stall !== e.st ||
            bus.irq_ack !== e.ack || bus.HLT !== e.hlt || bus.ctrl !== e.ctrl) begin
          n_errors++;
          $display("FAIL %s: got uaddr=%h ph=%b stall=%b ack=%b hlt=%b ctrl=%h exp uaddr=%h ph=%b stall=%b ack=%b hlt=%b ctrl=%h",
                   e.name, bus.uaddr, bus.phase_m, bus.stall, bus.irq_ack, bus.HLT, bus.ctrl,
                   e.ua, e.ph, e.st, e.ack, e.hlt, e.ctrl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mw(3'd0, 1'b0, 8'h00, 8'(i));
    rom[8'h03] = mw(3'd2, 1'b0, 8'h00, 8'h03);
    rom[8'h41] = mw(3'd1, 1'b0, 8'h10, 8'h41);
    rom[8'h46] = mw(3'd1, 1'b0, 8'h10, 8'h46);
    rom[8'h10] = mw(3'd4, 1'b0, 8'h20, 8'h10);
    rom[8'h20] = mw(3'd1, 1'b0, 8'hFF, 8'h20);
    rom[8'h11] = mw(3'd1, 1'b0, 8'hFF, 8'h11);
    rom[8'h00] = mw(3'd0, 1'b1, 8'h00, 8'h00);
    rom[8'h01] = mw(3'd3, 1'b0, 8'h00, 8'h01);
    rom[8'hFC] = mw(3'd1, 1'b0, 8'h30, 8'hFC);
    rom[8'h30] = mw(3'd0, 1'b1, 8'h00, 8'h30);
    rom[8'hFA] = mw(3'd1, 1'b0, 8'h02, 8'hFA);

    reset = 1'b1;
    bus.instr = 16'h8E00; bus.cond_true = 1'b0; bus.mem_ready = 1'b1;
    bus.trap_r = 1'b0; bus.irq_r = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    snap("rst_init", 8'd2, 1'b0);
    reset = 1'b0;

    // Reset mid-step at 0x47 (opcode 7 dispatch)
    cyc("t1_2m", 8'd2, 1'b1);
    cyc("t1_3s", 8'd3, 1'b0);
    cyc("t1_3m", 8'd3, 1'b1);
    cyc("t1_47s", 8'h47, 1'b0);
    cyc("t1_47m", 8'h47, 1'b1);
    reset = 1'b1;
    snap("t1_async", 8'd2, 1'b0);
    cyc("t1_hold", 8'd2, 1'b0);
    reset = 1'b0;

    // Dispatch 0x8C00 -> 70, CBR taken, wrap, wait, irq at END, trap in stall
    bus.instr = 16'h8C00; bus.irq_r = 1'b1; bus.cond_true = 1'b1;
    cyc("t2_2m", 8'd2, 1'b1);
    cyc("t2_3s", 8'd3, 1'b0);
    cyc("t2_3m", 8'd3, 1'b1);
    cyc("t2_disp70", 8'd70, 1'b0);
    cyc("t2_70m", 8'd70, 1'b1);
    cyc("t2_jmp10", 8'h10, 1'b0);
    cyc("t2_10m", 8'h10, 1'b1);
    cyc("t2_cbr_t", 8'h20, 1'b0);
    cyc("t2_20m", 8'h20, 1'b1);
    cyc("t2_ffs", 8'hFF, 1'b0);
    cyc("t2_ffm", 8'hFF, 1'b1);
    cyc("t2_wrap", 8'h00, 1'b0);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t4_stall", 8'h00, 1'b1, 1'b1);
    bus.mem_ready = 1'b1;
    cyc("t4_adv", 8'h01, 1'b0);
    cyc("t5_endm", 8'h01, 1'b1);
    cyc("t5_irq", 8'hFC, 1'b0, 1'b0, 1'b1);
    bus.irq_r = 1'b0;
    cyc("t5_ackoff", 8'hFC, 1'b1);
    cyc("t5_30s", 8'h30, 1'b0);
    bus.mem_ready = 1'b0;
    cyc("t5_30st", 8'h30, 1'b1, 1'b1);
    cyc("t5_30st2", 8'h30, 1'b1, 1'b1);
    bus.trap_r = 1'b1;
    cyc("t5_trap", 8'hFA, 1'b0);
    bus.trap_r = 1'b0; bus.mem_ready = 1'b1;
    cyc("t5_fam", 8'hFA, 1'b1);
    cyc("t5_back", 8'd2, 1'b0);

    // Short-form dispatch -> 65, CBR not taken, trap beats irq at END
    bus.instr = 16'h2000; bus.cond_true = 1'b0;
    cyc("t3_2m", 8'd2, 1'b1);
    cyc("t3_3s", 8'd3, 1'b0);
    cyc("t3_3m", 8'd3, 1'b1);
    cyc("t3_disp65", 8'd65, 1'b0);
    cyc("t3_65m", 8'd65, 1'b1);
    cyc("t3_10s", 8'h10, 1'b0);
    cyc("t3_10m", 8'h10, 1'b1);
    cyc("t3_cbr_nt", 8'h11, 1'b0);
    cyc("t3_11m", 8'h11, 1'b1);
    cyc("t3_ffs", 8'hFF, 1'b0);
    cyc("t3_ffm", 8'hFF, 1'b1);
    cyc("t3_wrap", 8'h00, 1'b0);
    cyc("t3_nowait", 8'h00, 1'b1);
    cyc("t3_01s", 8'h01, 1'b0);
    bus.trap_r = 1'b1; bus.irq_r = 1'b1;
    cyc("t3_setup_notrap", 8'h01, 1'b1);
    cyc("t3_trapwins", 8'hFA, 1'b0);
    bus.trap_r = 1'b0;
    cyc("t3_fam", 8'hFA, 1'b1);
    cyc("t3_jmp_noirq", 8'd2, 1'b0);
    bus.irq_r = 1'b0;

    // Halt instruction at dispatch; trap/irq ignored while halted
    bus.instr = 16'hfe00;
    cyc("t6_2m", 8'd2, 1'b1);
    cyc("t6_3s", 8'd3, 1'b0);
    cyc("t6_3m", 8'd3, 1'b1);
    cyc("t6_halt", 8'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.trap_r = 1'b1; bus.irq_r = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) cyc("t6_frozen", 8'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    snap("t6_rst", 8'd2, 1'b0);
    cyc("t6_rsthold", 8'd2, 1'b0);
    reset = 1'b0; bus.trap_r = 1'b0; bus.irq_r = 1'b0; bus.mem_ready = 1'b1;

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
